riscvlong_mem_arb: RTL

Two-to-one memory arbiter placed directly downstream of the 5-stage RISC-V core. It merges the core's instruction-memory and data-memory request ports onto a single shared memory request port. A small in-order tag FIFO records which port owns each outstanding request, and the shared memory response is routed back to the matching core port. This allows the core to run against a single-ported unified memory.

---
 rtl/riscvlong_mem_arb_pkg.sv | 43 ++++
 rtl/riscvlong_mem_arb_tagq.sv | 54 +++++
 rtl/riscvlong_mem_arb.sv | 104 ++++++++++
 3 files changed

// File: rtl/riscvlong_mem_arb_pkg.sv
// Shared definitions for the I/D memory arbiter: vc-style memory message layout
// and the source tags recorded for each outstanding request.
package riscvlong_mem_arb_pkg;

  // vc-MemReqMsg layout, MSB first: {type, addr, len, data}
  localparam int MEMREQ_TYPE_W = 1;
  localparam int MEMREQ_LEN_W  = 2;
  localparam int MEMREQ_ADDR_W = 32;
  localparam int MEMREQ_DATA_W = 32;
  localparam int MEMREQ_MSG_W  = MEMREQ_TYPE_W + MEMREQ_ADDR_W + MEMREQ_LEN_W + MEMREQ_DATA_W;

  // vc-MemRespMsg layout, MSB first: {type, len, data}
  localparam int MEMRESP_TYPE_W = 1;
  localparam int MEMRESP_LEN_W  = 2;
  localparam int MEMRESP_DATA_W = 32;
  localparam int MEMRESP_MSG_W  = MEMRESP_TYPE_W + MEMRESP_LEN_W + MEMRESP_DATA_W;

  localparam logic MEMREQ_TYPE_READ  = 1'b0;
  localparam logic MEMREQ_TYPE_WRITE = 1'b1;

  // Source tag pushed into the tag FIFO for each accepted request
  localparam logic ARB_SRC_I = 1'b0;
  localparam logic ARB_SRC_D = 1'b1;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_e;

  typedef struct packed {
    logic                     typ;
    logic [MEMREQ_ADDR_W-1:0] addr;
    logic [MEMREQ_LEN_W-1:0]  len;
    logic [MEMREQ_DATA_W-1:0] data;
  } memreq_msg_t;

  typedef struct packed {
    logic                      typ;
    logic [MEMRESP_LEN_W-1:0]  len;
    logic [MEMRESP_DATA_W-1:0] data;
  } memresp_msg_t;

endpackage

// File: rtl/riscvlong_mem_arb_tagq.sv
// 1-bit wide in-order FIFO holding the source tag of each in-flight request.
// Pointers wrap naturally; occupancy is tracked in a separate counter.
module riscvlong_mem_arb_tagq #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq,
  input  logic                     enq_bit,
  input  logic                     deq,
  output logic                     deq_bit,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_enq;
  logic             w_deq;

  // full/empty come from the registered count, so enq is never admitted on a
  // same-cycle deq when full: keeps deq off the enq timing path.
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign w_enq = enq & ~full;
  assign w_deq = deq & ~empty;

  assign deq_bit = r_mem[r_rptr];
  assign count   = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{PW{1'b0}}, w_enq} - {{PW{1'b0}}, w_deq};
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wptr] <= enq_bit;
  end

endmodule

// File: rtl/riscvlong_mem_arb.sv
// Round-robin 2:1 arbiter merging the core's I and D memory ports onto one
// shared memory port; responses are steered back by an in-order tag FIFO.
module riscvlong_mem_arb
  import riscvlong_mem_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_SZ         = 32,
  parameter int DATA_SZ         = 32
) (
  input  logic                               clk,
  input  logic                               reset,

  input  logic [ADDR_SZ+DATA_SZ+2:0]         imemreq_msg,
  input  logic                               imemreq_val,
  output logic                               imemreq_rdy,
  output logic [DATA_SZ+2:0]                 imemresp_msg,
  output logic                               imemresp_val,

  input  logic [ADDR_SZ+DATA_SZ+2:0]         dmemreq_msg,
  input  logic                               dmemreq_val,
  output logic                               dmemreq_rdy,
  output logic [DATA_SZ+2:0]                 dmemresp_msg,
  output logic                               dmemresp_val,

  output logic [ADDR_SZ+DATA_SZ+2:0]         memreq_msg,
  output logic                               memreq_val,
  input  logic                               memreq_rdy,
  input  logic [DATA_SZ+2:0]                 memresp_msg,
  input  logic                               memresp_val,

  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               proto_err
);

  arb_src_e r_last_grant;
  logic     r_proto_err;

  logic     w_grant_i;
  logic     w_grant_d;
  logic     w_req_val;
  logic     w_fire;
  logic     w_pop;
  logic     w_full;
  logic     w_empty;
  logic     w_head;
  logic     w_tag;

  // On conflict the side that did not win the last accepted request goes next.
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (imemreq_val && dmemreq_val) begin
      w_grant_i = (r_last_grant == SRC_D);
      w_grant_d = (r_last_grant == SRC_I);
    end else begin
      w_grant_i = imemreq_val;
      w_grant_d = dmemreq_val;
    end
  end

  // reset gating keeps every val/rdy output low while reset is held
  assign w_req_val = reset & ~w_full & (imemreq_val | dmemreq_val);
  assign w_fire    = w_req_val & memreq_rdy;
  assign w_tag     = w_grant_d ? ARB_SRC_D : ARB_SRC_I;

  assign memreq_val  = w_req_val;
  assign memreq_msg  = w_grant_d ? dmemreq_msg : imemreq_msg;
  assign imemreq_rdy = w_grant_i & w_fire;
  assign dmemreq_rdy = w_grant_d & w_fire;

  // A response with nothing outstanding is dropped and flagged, never popped.
  assign w_pop        = reset & memresp_val & ~w_empty;
  assign imemresp_val = w_pop & (w_head == ARB_SRC_I);
  assign dmemresp_val = w_pop & (w_head == ARB_SRC_D);
  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;

  assign proto_err = r_proto_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= SRC_D;
      r_proto_err  <= 1'b0;
    end else begin
      if (w_fire) r_last_grant <= w_grant_d ? SRC_D : SRC_I;
      if (memresp_val && w_empty) r_proto_err <= 1'b1;
    end
  end

  riscvlong_mem_arb_tagq #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tagq (
    .clk     (clk),
    .reset   (reset),
    .enq     (w_fire),
    .enq_bit (w_tag),
    .deq     (w_pop),
    .deq_bit (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (outstanding)
  );

endmodule
